alu_issue_stage: RTL

- Operand-issue and write-back stage wrapped around the 16-bit combinational ALU.
- Accepts decoded register-to-register or register-to-immediate instructions.
- Reads an 8x16 register file, forwarding an in-flight result when a source matches the pending destination.
- Registers operands and opcode onto the ALU inputs, then writes the ALU result back one cycle later.

---
 rtl/alu_issue_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Operand-issue and write-back stage around an external 16-bit combinational ALU.
// Reads an 8x16 register file with forwarding from the instruction currently in execute.
module alu_issue_stage #(
    parameter int unsigned NUM_REGS = 8,
    parameter logic [2:0]  IDLE_OP  = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_rs1,
    input  logic [2:0]  in_rs2,
    input  logic        in_use_imm,
    input  logic [15:0] in_imm,
    input  logic        hold,
    output logic [15:0] alu_operand1,
    output logic [15:0] alu_operand2,
    output logic [2:0]  alu_operation,
    input  logic [15:0] alu_result,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    input  logic [2:0]  dbg_rsel,
    output logic [15:0] dbg_rdata
);

    logic [15:0] rf_q [NUM_REGS];

    logic        ex_valid_q, ex_valid_d;
    logic [2:0]  ex_rd_q, ex_rd_d;
    logic [15:0] opnd1_q, opnd1_d;
    logic [15:0] opnd2_q, opnd2_d;
    logic [2:0]  opn_q, opn_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;

    logic        accept;
    logic        rf_we;
    logic [15:0] src1, src2, op2;

    assign in_ready = ~hold;
    assign accept   = in_valid & in_ready & ~rst;

    // Sources matching the pending destination take the live ALU result.
    always_comb begin
        src1 = '0;
        src2 = '0;
        if (in_rs1 != 3'd0) begin
            src1 = (ex_valid_q && ex_rd_q == in_rs1) ? alu_result : rf_q[in_rs1];
        end
        if (in_rs2 != 3'd0) begin
            src2 = (ex_valid_q && ex_rd_q == in_rs2) ? alu_result : rf_q[in_rs2];
        end
        op2 = in_use_imm ? in_imm : src2;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        opnd1_d    = opnd1_q;
        opnd2_d    = opnd2_q;
        opn_d      = opn_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        rf_we      = 1'b0;
        if (!hold) begin
            if (ex_valid_q) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_rd_q;
                wb_data_d  = alu_result;
                rf_we      = (ex_rd_q != 3'd0);
            end
            if (accept) begin
                ex_valid_d = 1'b1;
                ex_rd_d    = in_rd;
                opnd1_d    = src1;
                opnd2_d    = op2;
                opn_d      = in_op;
            end else begin
                ex_valid_d = 1'b0;
                opn_d      = IDLE_OP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            opn_q      <= IDLE_OP;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            if (rf_we) begin
                rf_q[ex_rd_q] <= alu_result;
            end
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            opnd1_q    <= opnd1_d;
            opnd2_q    <= opnd2_d;
            opn_q      <= opn_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign alu_operand1  = opnd1_q;
    assign alu_operand2  = opnd2_q;
    assign alu_operation = opn_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign dbg_rdata     = (dbg_rsel == 3'd0) ? 16'd0 : rf_q[dbg_rsel];

endmodule
